// File: rtl/full_adder_pkg.sv
// Shared result type for the full adder cell.
// Groups carry and sum so the registered copy moves as one word.
package full_adder_pkg;

  typedef struct packed {
    logic cout;
    logic sum;
  } fa_res_t;

endpackage

// File: rtl/full_adder_half_adder.sv
// Half adder leaf: s = x ^ y, c = x & y.
// Zero-cycle combinational path, no flow control.
module half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);

  assign s = x ^ y;
  assign c = x & y;

endmodule

// File: rtl/full_adder.sv
// 1-bit full adder from two half adders, plus an optional registered result copy.
// sum/cout are zero-latency; sum_q/cout_q follow one cycle later; no backpressure.
module full_adder
  import full_adder_pkg::*;
#(
  parameter int REG_OUT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout,
  output logic sum_q,
  output logic cout_q
);

  logic s0;
  logic c0;
  logic c1;

  half_adder ha0 (
    .x (a),
    .y (b),
    .s (s0),
    .c (c0)
  );

  half_adder ha1 (
    .x (s0),
    .y (cin),
    .s (sum),
    .c (c1)
  );

  // Both half-adder carries can never be 1 together, so OR is an exact merge.
  assign cout = c0 | c1;

  generate
    if (REG_OUT != 0) begin : g_reg
      fa_res_t res_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          res_q <= '0;
        end else begin
          res_q <= '{cout: cout, sum: sum};
        end
      end

      assign sum_q  = res_q.sum;
      assign cout_q = res_q.cout;
    end else begin : g_noreg
      // Clock and reset have no consumer without the output register.
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_n;

      assign sum_q  = 1'b0;
      assign cout_q = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder: reset, exhaustive sweep, latency, async reset, random stream.
module tb_full_adder;

  logic clk;
  logic rst_n;
  logic a;
  logic b;
  logic cin;
  logic sum;
  logic cout;
  logic sum_q;
  logic cout_q;
  logic sum0;
  logic cout0;
  logic sum_q0;
  logic cout_q0;

  int checks;
  int errors;

  full_adder #(.REG_OUT(1)) u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .a      (a),
    .b      (b),
    .cin    (cin),
    .sum    (sum),
    .cout   (cout),
    .sum_q  (sum_q),
    .cout_q (cout_q)
  );

  full_adder #(.REG_OUT(0)) u_dut_noreg (
    .clk    (clk),
    .rst_n  (rst_n),
    .a      (a),
    .b      (b),
    .cin    (cin),
    .sum    (sum0),
    .cout   (cout0),
    .sum_q  (sum_q0),
    .cout_q (cout_q0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [1:0] got, input logic [1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b expected=%b at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: the 2-bit unsigned total of three one-bit operands.
  function automatic logic [1:0] model(input logic x, input logic y, input logic z);
    int total;
    total = int'(x) + int'(y) + int'(z);
    return total[1:0];
  endfunction

  initial begin
    logic [2:0] v;
    logic [1:0] exp_q;

    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    a      = 1'b1;
    b      = 1'b1;
    cin    = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_comb", {cout, sum}, 2'b11);
    check("rst_reg", {cout_q, sum_q}, 2'b00);

    // Exhaustive sweep while reset is still held.
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      {a, b, cin} = v;
      #10;
      check("sweep_comb", {cout, sum}, model(v[2], v[1], v[0]));
      check("sweep_reg_in_rst", {cout_q, sum_q}, 2'b00);
      check("sweep_noreg_comb", {cout0, sum0}, model(v[2], v[1], v[0]));
    end
    {a, b, cin} = 3'b011;
    #1;
    check("tt_011", {cout, sum}, 2'b10);

    // Registered latency after release.
    @(negedge clk);
    rst_n = 1'b1;
    {a, b, cin} = 3'b101;
    #1;
    check("lat_before_edge", {cout_q, sum_q}, 2'b00);
    @(posedge clk);
    #1;
    check("lat_after_edge", {cout_q, sum_q}, 2'b10);

    // Asynchronous reset between edges.
    @(negedge clk);
    {a, b, cin} = 3'b100;
    @(posedge clk);
    #1;
    check("async_pre", {cout_q, sum_q}, 2'b01);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_clear", {cout_q, sum_q}, 2'b00);
    @(posedge clk);
    #1;
    check("async_hold", {cout_q, sum_q}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;

    // Random stream: combinational result now, registered copy after the next edge.
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      a   = 1'($urandom_range(1));
      b   = 1'($urandom_range(1));
      cin = 1'($urandom_range(1));
      exp_q = model(a, b, cin);
      #1;
      check("rand_comb", {cout, sum}, exp_q);
      check("rand_noreg_comb", {cout0, sum0}, exp_q);
      @(posedge clk);
      #1;
      check("rand_reg", {cout_q, sum_q}, exp_q);
      check("rand_noreg_q", {cout_q0, sum_q0}, 2'b00);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
